// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by pipeline_ctrl and fwd_unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_BUSY    = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a stage writes a real register whose index equals src.
    function automatic logic writes_src(input logic       reg_wr,
                                        input logic [4:0] rd,
                                        input logic [4:0] src);
        return reg_wr && (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: stage register indices in, stall/flush/forward controls out.
// master = pipeline datapath, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_md_start;
    logic       ex_br_taken;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_reg_wr;
    logic       wb_reg_wr;

    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       bubble_idex;
    logic       bubble_exmem;
    logic       flush_ifid;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       md_done;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_md_start, ex_br_taken,
        output mem_rd, wb_rd, mem_reg_wr, wb_reg_wr,
        input  stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem,
        input  flush_ifid, fwd_a, fwd_b, md_done
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_md_start, ex_br_taken,
        input  mem_rd, wb_rd, mem_reg_wr, wb_reg_wr,
        output stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem,
        output flush_ifid, fwd_a, fwd_b, md_done
    );
endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding select for one EX source register.
// MEM result beats WB result; x0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_wr,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_wr,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (writes_src(mem_reg_wr, mem_rd, rs)) begin
            sel = FWD_MEM;
        end else if (writes_src(wb_reg_wr, wb_rd, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-branch flushes, forwarding, and mul/div EX occupancy when PIPE_MULDIV_EN is defined.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input logic           clk,
    input logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_e state;
    logic        load_use;
    logic        md_busy;
    logic        md_last;
    logic        md_start;
    fwd_sel_e    sel_a;
    fwd_sel_e    sel_b;

    assign load_use = (state == RUN) && bus.ex_is_load && (bus.ex_rd != REG_ZERO) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

`ifdef PIPE_MULDIV_EN
    logic [3:0] md_cnt;

    assign md_busy  = (state == MD_BUSY);
    assign md_last  = md_busy && (md_cnt == 4'd0);
    assign md_start = (state == RUN) && bus.ex_md_start && !bus.ex_br_taken;
`else
    logic unused_md;

    assign md_busy   = 1'b0;
    assign md_last   = 1'b0;
    assign md_start  = 1'b0;
    assign unused_md = ^{bus.ex_md_start, 4'(MD_LAT)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
`ifdef PIPE_MULDIV_EN
            md_cnt <= '0;
`endif
        end else if (bus.ex_br_taken) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state <= MD_BUSY;
`ifdef PIPE_MULDIV_EN
                        md_cnt <= 4'(MD_LAT - 1);
`endif
                    end else if (load_use) begin
                        state <= LOAD_STALL;
                    end
                end
                LOAD_STALL: state <= RUN;
`ifdef PIPE_MULDIV_EN
                MD_BUSY: begin
                    if (md_last) begin
                        state <= RUN;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
`endif
                default: state <= RUN;
            endcase
        end
    end

    // Outputs are combinational so the pipeline registers see them before the
    // edge they act on; reset forces every control to its inactive value.
    always_comb begin
        bus.stall_pc     = 1'b0;
        bus.stall_ifid   = 1'b0;
        bus.stall_idex   = 1'b0;
        bus.bubble_idex  = 1'b0;
        bus.bubble_exmem = 1'b0;
        bus.flush_ifid   = 1'b0;
        bus.md_done      = 1'b0;
        if (!rst_n) begin
            bus.stall_pc = 1'b0;
        end else if (bus.ex_br_taken) begin
            bus.flush_ifid  = 1'b1;
            bus.bubble_idex = 1'b1;
        end else if (md_busy) begin
            bus.bubble_exmem = 1'b1;
            if (md_last) begin
                bus.md_done = 1'b1;
            end else begin
                bus.stall_pc   = 1'b1;
                bus.stall_ifid = 1'b1;
                bus.stall_idex = 1'b1;
            end
        end else if (load_use) begin
            bus.stall_pc    = 1'b1;
            bus.stall_ifid  = 1'b1;
            bus.bubble_idex = 1'b1;
        end
    end

    fwd_unit u_fwd_a (
        .rs         (bus.ex_rs1),
        .mem_rd     (bus.mem_rd),
        .mem_reg_wr (bus.mem_reg_wr),
        .wb_rd      (bus.wb_rd),
        .wb_reg_wr  (bus.wb_reg_wr),
        .sel        (sel_a)
    );

    fwd_unit u_fwd_b (
        .rs         (bus.ex_rs2),
        .mem_rd     (bus.mem_rd),
        .mem_reg_wr (bus.mem_reg_wr),
        .wb_rd      (bus.wb_rd),
        .wb_reg_wr  (bus.wb_reg_wr),
        .sel        (sel_b)
    );

    assign bus.fwd_a = rst_n ? sel_a : '0;
    assign bus.fwd_b = rst_n ? sel_b : '0;

    a_md_br_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ex_md_start && bus.ex_br_taken));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; control outputs packed as
// {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, md_done}.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MD_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LDUSE = 7'b1101000;
    localparam logic [6:0] C_BR    = 7'b0001010;
    localparam logic [6:0] C_MD    = 7'b1110100;
    localparam logic [6:0] C_MDEND = 7'b0000101;

    function automatic logic [6:0] ctl();
        return {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.bubble_idex,
                bus.bubble_exmem, bus.flush_ifid, bus.md_done};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_is_load = 1'b0;
        bus.ex_md_start = 1'b0; bus.ex_br_taken = 1'b0;
        bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_reg_wr = 1'b0; bus.wb_reg_wr = 1'b0;
    endtask

    // lw x5 in EX, add x6,x5,x7 in ID
    task automatic hazard();
        idle();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();

        // Reset with a hazard and a forwarding match presented: everything stays 0.
        step(); hazard();
        bus.ex_rs1 = 5'd3; bus.mem_rd = 5'd3; bus.mem_reg_wr = 1'b1;
        #1 chk("reset_ctl", {1'b0, ctl()}, {1'b0, C_NONE});
        chk("reset_fwd_a", {6'd0, bus.fwd_a}, 8'd0);

        step(); rst_n = 1'b1; idle();
        #1 chk("idle_ctl", {1'b0, ctl()}, {1'b0, C_NONE});

        // Load-use on rs1: one stall cycle, LOAD_STALL hides it, RUN sees it again.
        step(); hazard();
        #1 chk("lduse_rs1", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step();
        #1 chk("load_stall_quiet", {1'b0, ctl()}, {1'b0, C_NONE});
        step();
        #1 chk("back_to_run", {1'b0, ctl()}, {1'b0, C_LDUSE});

        // The add reaches EX behind the bubble; loaded x5 is in WB.
        step(); idle();
        bus.ex_rs1 = 5'd5; bus.ex_rs2 = 5'd7; bus.ex_rd = 5'd6;
        bus.wb_rd = 5'd5; bus.wb_reg_wr = 1'b1;
        #1 chk("add_fwd_a_wb", {6'd0, bus.fwd_a}, 8'b10);
        chk("add_fwd_b_rf", {6'd0, bus.fwd_b}, 8'b00);
        chk("add_ctl", {1'b0, ctl()}, {1'b0, C_NONE});

        // Use flags gate detection: x9 only as an unused rs1, then as a used rs2.
        step(); idle();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9;
        bus.id_rs1 = 5'd9; bus.id_rs2 = 5'd4; bus.id_use_rs2 = 1'b1;
        #1 chk("lduse_unused_src", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); bus.id_rs2 = 5'd9;
        #1 chk("lduse_rs2", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); idle();
        #1 chk("rs2_stall_over", {1'b0, ctl()}, {1'b0, C_NONE});

        // Load to x0 and x0 writers in MEM/WB: no stall, no forwarding.
        step(); idle();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        bus.mem_reg_wr = 1'b1; bus.wb_reg_wr = 1'b1;
        #1 chk("x0_load_ctl", {1'b0, ctl()}, {1'b0, C_NONE});
        chk("x0_fwd_a", {6'd0, bus.fwd_a}, 8'b00);
        chk("x0_fwd_b", {6'd0, bus.fwd_b}, 8'b00);

        // Forwarding priority: MEM beats WB.
        step(); idle();
        bus.mem_rd = 5'd3; bus.wb_rd = 5'd3; bus.mem_reg_wr = 1'b1; bus.wb_reg_wr = 1'b1;
        bus.ex_rs1 = 5'd4; bus.ex_rs2 = 5'd3;
        #1 chk("fwd_b_mem", {6'd0, bus.fwd_b}, 8'b01);
        chk("fwd_a_none", {6'd0, bus.fwd_a}, 8'b00);
        bus.mem_reg_wr = 1'b0;
        #1 chk("fwd_b_wb", {6'd0, bus.fwd_b}, 8'b10);
        bus.mem_rd = 5'd4; bus.mem_reg_wr = 1'b1;
        #1 chk("fwd_a_mem_split", {6'd0, bus.fwd_a}, 8'b01);
        chk("fwd_b_wb_split", {6'd0, bus.fwd_b}, 8'b10);

        // Taken branch overrides a load-use hazard and cancels the stall.
        step(); hazard(); bus.ex_br_taken = 1'b1;
        #1 chk("br_over_lduse", {1'b0, ctl()}, {1'b0, C_BR});
        step(); hazard();
        #1 chk("br_cancel_run", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); idle(); bus.ex_br_taken = 1'b1;
        #1 chk("br_in_load_stall", {1'b0, ctl()}, {1'b0, C_BR});
        step(); idle();
        #1 chk("after_br_idle", {1'b0, ctl()}, {1'b0, C_NONE});

`ifdef PIPE_MULDIV_EN
        // MD_LAT=4: start, three held cycles, done on the fourth.
        step(); idle(); bus.ex_md_start = 1'b1;
        #1 chk("md_start_cycle", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); idle();
        #1 chk("md_busy1", {1'b0, ctl()}, {1'b0, C_MD});
        step(); bus.ex_md_start = 1'b1;
        #1 chk("md_busy2_restart_ignored", {1'b0, ctl()}, {1'b0, C_MD});
        step(); hazard();
        #1 chk("md_busy3_over_lduse", {1'b0, ctl()}, {1'b0, C_MD});
        step(); idle();
        #1 chk("md_done", {1'b0, ctl()}, {1'b0, C_MDEND});
        step();
        #1 chk("md_back_run", {1'b0, ctl()}, {1'b0, C_NONE});

        // Branch during MD_BUSY aborts it.
        step(); bus.ex_md_start = 1'b1;
        step(); idle();
        #1 chk("md_pre_branch", {1'b0, ctl()}, {1'b0, C_MD});
        step(); bus.ex_br_taken = 1'b1;
        #1 chk("md_branch", {1'b0, ctl()}, {1'b0, C_BR});
        step(); idle();
        #1 chk("md_branch_run", {1'b0, ctl()}, {1'b0, C_NONE});

        // Reset in the second MD_BUSY cycle.
        step(); bus.ex_md_start = 1'b1;
        step(); idle();
        #1 chk("md_rst_busy1", {1'b0, ctl()}, {1'b0, C_MD});
        step(); #1 rst_n = 1'b0;
        #1 chk("md_rst_low", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); rst_n = 1'b1;
        #1 chk("md_rst_release", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); hazard();
        #1 chk("md_rst_run_lduse", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); idle();
`else
        // Without mul/div support the start pulse is ignored.
        step(); idle(); bus.ex_md_start = 1'b1;
        #1 chk("md_off_start", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); idle();
        #1 chk("md_off_next", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); hazard();
        #1 chk("md_off_run_lduse", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); idle();
`endif

        // Reset during LOAD_STALL, then a hazard right after release is seen in RUN.
        step(); hazard();
        #1 chk("ls_rst_stall", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); #1 rst_n = 1'b0;
        #1 chk("ls_rst_low", {1'b0, ctl()}, {1'b0, C_NONE});
        step(); rst_n = 1'b1;
        #1 chk("ls_rst_release_run", {1'b0, ctl()}, {1'b0, C_LDUSE});
        step(); idle();
        #1 chk("ls_rst_final", {1'b0, ctl()}, {1'b0, C_NONE});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
